// File: rtl/issue_pkg.sv
// Shared definitions for the issue stage: queue-entry layout, decoded-field types and scoreboard sizing.
package issue_pkg;

  localparam int NUM_REGS     = 32;
  localparam int REG_W        = 5;
  localparam int PC_W         = 32;
  localparam int IMM_W        = 32;
  localparam int DATA_W       = 32;
  localparam int OPRT_W       = 4;
  localparam int OPND_W       = 2;
  localparam int FUNC_W       = 2;
  localparam int ENTRY_USED_W = 121;

  localparam int ENT_TAKEN  = 0;
  localparam int ENT_NXT_PC = 1;
  localparam int ENT_CUR_PC = 33;
  localparam int ENT_RD_WEN = 65;
  localparam int ENT_RD     = 66;
  localparam int ENT_RS2    = 71;
  localparam int ENT_RS1    = 76;
  localparam int ENT_IMM    = 81;
  localparam int ENT_OPRT   = 113;
  localparam int ENT_OPND   = 117;
  localparam int ENT_FUNC   = 119;

  typedef enum logic [1:0] {
    FUNC_ALU = 2'd0, FUNC_BRU = 2'd1, FUNC_LSU = 2'd2, FUNC_CSR = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    OPND_REG_REG = 2'd0, OPND_REG_IMM = 2'd1, OPND_PC_IMM = 2'd2, OPND_NONE = 2'd3
  } opnd_e;

  typedef enum logic [3:0] {
    OPRT_ADD = 4'd0, OPRT_SUB = 4'd1, OPRT_AND = 4'd2, OPRT_OR  = 4'd3,
    OPRT_XOR = 4'd4, OPRT_SLL = 4'd5, OPRT_SRL = 4'd6, OPRT_SRA = 4'd7
  } oprt_e;

  typedef enum logic {EX_EMPTY = 1'b0, EX_FULL = 1'b1} ex_state_e;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [OPND_W-1:0] opnd;
    logic [OPRT_W-1:0] oprt;
    logic [IMM_W-1:0]  imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              rd_wen;
    logic [PC_W-1:0]   cur_pc;
    logic [PC_W-1:0]   nxt_pc;
    logic              taken;
  } issue_entry_t;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [OPND_W-1:0] opnd;
    logic [OPRT_W-1:0] oprt;
    logic [IMM_W-1:0]  imm;
    logic [REG_W-1:0]  rd;
    logic              rd_wen;
    logic [PC_W-1:0]   cur_pc;
    logic [PC_W-1:0]   nxt_pc;
    logic              taken;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
  } ex_op_t;

  function automatic issue_entry_t decode_entry(input logic [ENTRY_USED_W-1:0] raw);
    issue_entry_t e;
    e.taken  = raw[ENT_TAKEN];
    e.nxt_pc = raw[ENT_NXT_PC +: PC_W];
    e.cur_pc = raw[ENT_CUR_PC +: PC_W];
    e.rd_wen = raw[ENT_RD_WEN];
    e.rd     = raw[ENT_RD +: REG_W];
    e.rs2    = raw[ENT_RS2 +: REG_W];
    e.rs1    = raw[ENT_RS1 +: REG_W];
    e.imm    = raw[ENT_IMM +: IMM_W];
    e.oprt   = raw[ENT_OPRT +: OPRT_W];
    e.opnd   = raw[ENT_OPND +: OPND_W];
    e.func   = raw[ENT_FUNC +: FUNC_W];
    return e;
  endfunction

endpackage

// File: rtl/issue_stage_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per architectural register, x0 never busy.
module issue_scoreboard
  import issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             wb_clr_en,
  input  logic [REG_W-1:0] wb_clr_idx,
  input  logic             flush_clr_en,
  input  logic [REG_W-1:0] flush_clr_idx,
  input  logic [REG_W-1:0] look1_idx,
  input  logic [REG_W-1:0] look2_idx,
  input  logic [REG_W-1:0] look3_idx,
  output logic             look1_busy,
  output logic             look2_busy,
  output logic             look3_busy
);

  localparam logic [NUM_REGS-1:0] BIT0  = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] ZEROS = {NUM_REGS{1'b0}};

  logic [NUM_REGS-1:0] busy_q, busy_d, set_mask_s, clr_mask_s;

  // Clears apply before the set so a same-cycle set on the same index wins.
  always_comb begin
    set_mask_s = set_en ? (BIT0 << set_idx) : ZEROS;
    clr_mask_s = (wb_clr_en ? (BIT0 << wb_clr_idx) : ZEROS)
               | (flush_clr_en ? (BIT0 << flush_clr_idx) : ZEROS);
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~BIT0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= ZEROS;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign look1_busy = busy_q[look1_idx];
  assign look2_busy = busy_q[look2_idx];
  assign look3_busy = busy_q[look3_idx];

endmodule

// File: rtl/issue_stage.sv
// In-order issue stage: scoreboard hazard check, operand read and a one-deep output register to execute.
// Define ISSUE_WB_BYPASS_EN to forward same-cycle writeback data into a popping micro-op.
module issue_stage
  import issue_pkg::*;
#(
  parameter int ISSUE_Q_WIDTH   = 123,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int RD_WIDTH        = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       issue_q_rok,
  input  logic [ISSUE_Q_WIDTH-1:0]   issue_q_rdata,
  output logic                       issue_q_ren,
  input  logic                       bpu_flush,
  output logic [RD_WIDTH-1:0]        rf_raddr1,
  output logic [RD_WIDTH-1:0]        rf_raddr2,
  input  logic [DATA_WIDTH-1:0]      rf_rdata1,
  input  logic [DATA_WIDTH-1:0]      rf_rdata2,
  input  logic                       wb_valid,
  input  logic [RD_WIDTH-1:0]        wb_rd,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  input  logic                       ex_ready,
  output logic                       ex_valid,
  output logic [1:0]                 ex_func,
  output logic [1:0]                 ex_opnd,
  output logic [3:0]                 ex_oprt,
  output logic [31:0]                ex_imm,
  output logic [RD_WIDTH-1:0]        ex_rd,
  output logic                       ex_rd_wen,
  output logic [ADDR_WIDTH-1:0]      ex_cur_pc,
  output logic [ADDR_WIDTH-1:0]      ex_nxt_pc,
  output logic                       ex_taken,
  output logic [DATA_WIDTH-1:0]      ex_rs1_data,
  output logic [DATA_WIDTH-1:0]      ex_rs2_data,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = {STALL_CNT_WIDTH{1'b1}};
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

  issue_entry_t                head_s;
  ex_state_e                   state_q, state_d;
  ex_op_t                      op_q, op_d;
  logic [STALL_CNT_WIDTH-1:0]  stall_q, stall_d;
  logic rs1_busy_raw_s, rs2_busy_raw_s, rd_busy_s;
  logic fwd1_s, fwd2_s, hazard_s, pop_s, sb_set_s, sb_flush_clr_s;
  logic unused_s;

  assign head_s    = decode_entry(issue_q_rdata[ENTRY_USED_W-1:0]);
  assign rf_raddr1 = head_s.rs1;
  assign rf_raddr2 = head_s.rs2;

`ifdef ISSUE_WB_BYPASS_EN
  assign fwd1_s   = wb_valid & (wb_rd == head_s.rs1) & (head_s.rs1 != 5'd0);
  assign fwd2_s   = wb_valid & (wb_rd == head_s.rs2) & (head_s.rs2 != 5'd0);
  assign unused_s = ^issue_q_rdata[ISSUE_Q_WIDTH-1:ENTRY_USED_W];
`else
  assign fwd1_s   = 1'b0;
  assign fwd2_s   = 1'b0;
  assign unused_s = ^{issue_q_rdata[ISSUE_Q_WIDTH-1:ENTRY_USED_W], wb_data};
`endif

  assign hazard_s = (rs1_busy_raw_s & ~fwd1_s) | (rs2_busy_raw_s & ~fwd2_s)
                  | (head_s.rd_wen & rd_busy_s);
  assign ex_valid = (state_q == EX_FULL);
  // RSTN gates the pop so the queue is never drained while the stage is held in reset.
  assign pop_s    = RSTN & issue_q_rok & ~hazard_s & (~ex_valid | ex_ready) & ~bpu_flush;
  assign issue_q_ren = pop_s;

  assign sb_set_s       = pop_s & head_s.rd_wen & (head_s.rd != 5'd0);
  assign sb_flush_clr_s = bpu_flush & ex_valid & ~ex_ready & op_q.rd_wen;

  issue_scoreboard u_scoreboard (
    .clk           (CLK),
    .rst_n         (RSTN),
    .set_en        (sb_set_s),
    .set_idx       (head_s.rd),
    .wb_clr_en     (wb_valid),
    .wb_clr_idx    (wb_rd),
    .flush_clr_en  (sb_flush_clr_s),
    .flush_clr_idx (op_q.rd),
    .look1_idx     (head_s.rs1),
    .look2_idx     (head_s.rs2),
    .look3_idx     (head_s.rd),
    .look1_busy    (rs1_busy_raw_s),
    .look2_busy    (rs2_busy_raw_s),
    .look3_busy    (rd_busy_s)
  );

  // Output-register occupancy: flush dominates, a pop keeps it full, an accept alone empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EX_EMPTY: state_d = pop_s ? EX_FULL : EX_EMPTY;
      EX_FULL: begin
        if (bpu_flush) begin
          state_d = EX_EMPTY;
        end else if (pop_s) begin
          state_d = EX_FULL;
        end else if (ex_ready) begin
          state_d = EX_EMPTY;
        end else begin
          state_d = EX_FULL;
        end
      end
      default: state_d = EX_EMPTY;
    endcase
  end

  // Payload and saturating stall counter next values.
  always_comb begin
    op_d = op_q;
    if (pop_s) begin
      op_d.func     = head_s.func;
      op_d.opnd     = head_s.opnd;
      op_d.oprt     = head_s.oprt;
      op_d.imm      = head_s.imm;
      op_d.rd       = head_s.rd;
      op_d.rd_wen   = head_s.rd_wen;
      op_d.cur_pc   = head_s.cur_pc;
      op_d.nxt_pc   = head_s.nxt_pc;
      op_d.taken    = head_s.taken;
      op_d.rs1_data = fwd1_s ? wb_data : rf_rdata1;
      op_d.rs2_data = fwd2_s ? wb_data : rf_rdata2;
    end else begin
      op_d = op_q;
    end
    if (issue_q_rok && hazard_s && !bpu_flush && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State, payload and counter registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= EX_EMPTY;
      op_q    <= '0;
      stall_q <= {STALL_CNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      stall_q <= stall_d;
    end
  end

  assign ex_func     = op_q.func;
  assign ex_opnd     = op_q.opnd;
  assign ex_oprt     = op_q.oprt;
  assign ex_imm      = op_q.imm;
  assign ex_rd       = op_q.rd;
  assign ex_rd_wen   = op_q.rd_wen;
  assign ex_cur_pc   = op_q.cur_pc;
  assign ex_nxt_pc   = op_q.nxt_pc;
  assign ex_taken    = op_q.taken;
  assign ex_rs1_data = op_q.rs1_data;
  assign ex_rs2_data = op_q.rs2_data;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios plus random traffic against a cycle-level model.
module tb_issue_stage;

  localparam int SMAX = 65535;
`ifdef ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RSTN;
  logic         issue_q_rok, issue_q_ren, bpu_flush;
  logic [122:0] issue_q_rdata;
  logic [4:0]   rf_raddr1, rf_raddr2, wb_rd, ex_rd;
  logic [31:0]  rf_rdata1, rf_rdata2, wb_data, ex_imm, ex_cur_pc, ex_nxt_pc, ex_rs1_data, ex_rs2_data;
  logic         wb_valid, ex_ready, ex_valid, ex_rd_wen, ex_taken;
  logic [1:0]   ex_func, ex_opnd;
  logic [3:0]   ex_oprt;
  logic [15:0]  stall_cnt;

  int tests = 0;
  int fails = 0;

  bit [31:0]    m_busy;
  bit           m_valid;
  logic [122:0] m_ent;
  logic [31:0]  m_d1, m_d2;
  int           m_stall;
  logic [122:0] q[$];

  always #5 CLK = ~CLK;

  issue_stage dut (
    .CLK(CLK), .RSTN(RSTN), .issue_q_rok(issue_q_rok), .issue_q_rdata(issue_q_rdata),
    .issue_q_ren(issue_q_ren), .bpu_flush(bpu_flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_func(ex_func),
    .ex_opnd(ex_opnd), .ex_oprt(ex_oprt), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
    .ex_cur_pc(ex_cur_pc), .ex_nxt_pc(ex_nxt_pc), .ex_taken(ex_taken),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return {a, 27'h2A5C3F1} ^ 32'h0000_0F0F;
  endfunction

  assign rf_rdata1 = rf_val(rf_raddr1);
  assign rf_rdata2 = rf_val(rf_raddr2);

  function automatic logic [122:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic wen);
    logic [31:0] imm, cpc;
    imm = $urandom;
    cpc = $urandom;
    return {2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), imm, rs1, rs2, rd, wen,
            cpc, cpc + 32'd4, 1'($urandom)};
  endfunction

  function automatic logic [191:0] ex_vec();
    return {17'd0, ex_func, ex_opnd, ex_oprt, ex_imm, ex_rd, ex_rd_wen, ex_cur_pc, ex_nxt_pc,
            ex_taken, ex_rs1_data, ex_rs2_data};
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_ready  = 1'b1;
    bpu_flush = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
  endtask

  // One clock: present queue head, check pop decision, advance model, check registered outputs.
  task automatic step(output logic ren_o);
    logic [122:0] h;
    logic rok, f1, f2, haz, exp_ren, acc;
    rok = (q.size() > 0);
    h = rok ? q[0] : 123'd0;
    issue_q_rok   = rok;
    issue_q_rdata = h;
    #1;
    f1 = BYP && wb_valid && (wb_rd == h[80:76]) && (h[80:76] != 5'd0);
    f2 = BYP && wb_valid && (wb_rd == h[75:71]) && (h[75:71] != 5'd0);
    haz = (m_busy[h[80:76]] && !f1) || (m_busy[h[75:71]] && !f2) || (h[65] && m_busy[h[70:66]]);
    exp_ren = rok && !haz && (!m_valid || ex_ready) && !bpu_flush;
    check("ren", issue_q_ren, exp_ren);
    check("raddr", {rf_raddr1, rf_raddr2}, h[80:71]);
    ren_o = issue_q_ren;
    @(posedge CLK);
    acc = m_valid && ex_ready;
    if (rok && haz && !bpu_flush && m_stall < SMAX) m_stall++;
    if (wb_valid) m_busy[wb_rd] = 1'b0;
    if (bpu_flush) begin
      if (m_valid && !ex_ready && m_ent[65]) m_busy[m_ent[70:66]] = 1'b0;
      m_valid = 1'b0;
    end
    if (exp_ren) begin
      m_ent   = h;
      m_d1    = f1 ? wb_data : rf_val(h[80:76]);
      m_d2    = f2 ? wb_data : rf_val(h[75:71]);
      m_valid = 1'b1;
      if (h[65] && h[70:66] != 5'd0) m_busy[h[70:66]] = 1'b1;
      void'(q.pop_front());
    end else if (acc) begin
      m_valid = 1'b0;
    end
    m_busy[0] = 1'b0;
    #1;
    check("ex_valid", ex_valid, m_valid);
    check("stall_cnt", stall_cnt, m_stall[15:0]);
    if (m_valid) check("ex_fields", ex_vec(), {17'd0, m_ent[120:81], m_ent[70:0], m_d1, m_d2});
    @(negedge CLK);
  endtask

  task automatic clear_all();
    logic d;
    for (int r = 1; r < 32; r++) begin
      if (m_busy[r]) begin
        wb_valid = 1'b1;
        wb_rd = 5'(r);
        step(d);
      end
    end
    wb_valid = 1'b0;
  endtask

  initial begin
    logic r, r2;
    logic [191:0] snap;
    m_busy = 32'd0; m_valid = 1'b0; m_stall = 0; m_ent = 123'd0;

    // Reset: outputs cleared and no pop even with a hazard-free head present.
    RSTN = 1'b0;
    idle();
    issue_q_rok = 1'b1;
    issue_q_rdata = mk(5'd1, 5'd2, 5'd3, 1'b1);
    #2;
    check("reset_ren", issue_q_ren, 1'b0);
    check("reset_valid", ex_valid, 1'b0);
    check("reset_data", ex_vec(), 192'd0);
    check("reset_stall", stall_cnt, 16'd0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;

    // Independent stream of four.
    for (int i = 0; i < 4; i++) q.push_back(mk(5'd12, 5'd13, 5'(8 + i), 1'b1));
    for (int i = 0; i < 4; i++) begin
      step(r);
      check("indep_ren", r, 1'b1);
      check("indep_valid", ex_valid, 1'b1);
    end
    step(r);
    check("indep_drain", ex_valid, 1'b0);
    check("indep_stall", stall_cnt, 16'd0);
    clear_all();

    // RAW dependency released by writeback of x5.
    q.push_back(mk(5'd1, 5'd2, 5'd5, 1'b1));
    q.push_back(mk(5'd5, 5'd0, 5'd6, 1'b1));
    step(r);
    check("raw_a_pop", r, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(r);
      check("raw_b_blocked", r, 1'b0);
    end
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    step(r);
    if (r) check("raw_data", ex_rs1_data, BYP ? 32'hDEADBEEF : rf_val(5'd5));
    wb_valid = 1'b0;
    step(r2);
    if (r2) check("raw_data", ex_rs1_data, BYP ? 32'hDEADBEEF : rf_val(5'd5));
    check("raw_pop_cycle", {r, r2}, BYP ? 2'b10 : 2'b01);
    step(r);
    clear_all();

    // Backpressure holds outputs and blocks pops.
    q.push_back(mk(5'd14, 5'd15, 5'd16, 1'b1));
    q.push_back(mk(5'd17, 5'd18, 5'd19, 1'b1));
    step(r);
    check("bp_pop", r, 1'b1);
    snap = ex_vec();
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(r);
      check("bp_no_pop", r, 1'b0);
      check("bp_hold", ex_vec(), snap);
      check("bp_valid", ex_valid, 1'b1);
    end
    ex_ready = 1'b1;
    step(r);
    check("bp_resume", r, 1'b1);
    step(r);
    clear_all();

    // Flush of an unaccepted op with rd=7 releases its consumer.
    q.push_back(mk(5'd20, 5'd21, 5'd7, 1'b1));
    step(r);
    ex_ready = 1'b0;
    q.push_back(mk(5'd7, 5'd22, 5'd23, 1'b1));
    step(r);
    check("fl_blocked", r, 1'b0);
    bpu_flush = 1'b1;
    step(r);
    check("fl_no_pop", r, 1'b0);
    check("fl_valid", ex_valid, 1'b0);
    bpu_flush = 1'b0; ex_ready = 1'b1;
    step(r);
    check("fl_busy7_clear", r, 1'b1);
    step(r);
    clear_all();

    // x0 never busy; same-cycle clear and set on x3 leaves it busy.
    q.push_back(mk(5'd24, 5'd25, 5'd0, 1'b1));
    q.push_back(mk(5'd0, 5'd0, 5'd0, 1'b1));
    step(r);
    check("x0_pop1", r, 1'b1);
    step(r);
    check("x0_pop2", r, 1'b1);
    q.push_back(mk(5'd26, 5'd27, 5'd3, 1'b1));
    wb_valid = 1'b1; wb_rd = 5'd3;
    step(r);
    check("col_pop", r, 1'b1);
    wb_valid = 1'b0;
    q.push_back(mk(5'd3, 5'd0, 5'd28, 1'b1));
    for (int i = 0; i < 2; i++) begin
      step(r);
      check("col_busy3", r, 1'b0);
    end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234_5678;
    step(r);
    check("col_release", r, BYP);
    wb_valid = 1'b0;
    step(r);
    step(r);
    clear_all();

    // Random traffic over a small register set.
    for (int c = 0; c < 600; c++) begin
      while (q.size() < 3)
        q.push_back(mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 1'($urandom)));
      ex_ready  = ($urandom_range(0, 3) != 0);
      bpu_flush = ($urandom_range(0, 15) == 0);
      wb_valid  = 1'($urandom);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      step(r);
    end
    idle();
    for (int i = 0; i < 64; i++) begin
      wb_valid = 1'b1;
      wb_rd = 5'(i % 8);
      step(r);
    end
    wb_valid = 1'b0;
    step(r);
    clear_all();

    // Reset mid-operation discards held op and scoreboard immediately.
    q.push_back(mk(5'd1, 5'd2, 5'd9, 1'b1));
    q.push_back(mk(5'd9, 5'd0, 5'd10, 1'b1));
    step(r);
    ex_ready = 1'b0;
    step(r);
    RSTN = 1'b0;
    #1;
    check("rst_valid", ex_valid, 1'b0);
    check("rst_ren", issue_q_ren, 1'b0);
    check("rst_stall", stall_cnt, 16'd0);
    check("rst_data", ex_vec(), 192'd0);
    m_busy = 32'd0; m_valid = 1'b0; m_stall = 0;
    @(negedge CLK);
    RSTN = 1'b1;
    ex_ready = 1'b1;
    step(r);
    check("rst_sb_cleared", r, 1'b1);
    step(r);
    clear_all();

    // Stall counter saturation.
    q.push_back(mk(5'd1, 5'd2, 5'd5, 1'b1));
    step(r);
    q.push_back(mk(5'd5, 5'd0, 5'd6, 1'b1));
    for (int i = 0; i < 70000; i++) step(r);
    check("sat_cnt", stall_cnt, 16'hFFFF);
    wb_valid = 1'b1; wb_rd = 5'd5;
    step(r);
    wb_valid = 1'b0;
    step(r);
    check("sat_hold", stall_cnt, 16'hFFFF);
    clear_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
# issue_stage

Back-end issue stage directly downstream of the front-end issue queue. Pops decoded entries in order and blocks on RAW/WAW hazards using a 32-entry busy-bit scoreboard. Reads operands from the external register file and holds one dispatched micro-op in an output register for the execute stage under a valid/ready handshake. Writeback from execute clears scoreboard bits; branch flush squashes the held micro-op.

## Interface
- ISSUE_Q_WIDTH, 123, issue-queue entry width
- DATA_WIDTH, 32, operand width
- ADDR_WIDTH, 32, PC width
- RD_WIDTH, 5, register index width (32 architectural registers)
- STALL_CNT_WIDTH, 16, hazard-stall counter width

- CLK  in  1  clock; all state on rising edge
- RSTN  in  1  asynchronous, active-low reset
- issue_q_rok  in  1  queue non-empty; issue_q_rdata valid (first-word fall-through)
- issue_q_rdata  in  ISSUE_Q_WIDTH  head entry
- issue_q_ren  out  1  pop head this cycle
- bpu_flush  in  1  squash held micro-op, block pop this cycle
- rf_raddr1 / rf_raddr2  out  5  register-file read addresses (combinational read)
- rf_rdata1 / rf_rdata2  in  32  register-file read data
- wb_valid  in  1  writeback this cycle
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value (used only with bypass)
- ex_ready  in  1  execute accepts held micro-op
- ex_valid  out  1  held micro-op valid
- ex_func 2, ex_opnd 2, ex_oprt 4, ex_imm 32, ex_rd 5, ex_rd_wen 1, ex_cur_pc 32, ex_nxt_pc 32, ex_taken 1  out  decoded fields, registered
- ex_rs1_data / ex_rs2_data  out  32  registered operands
- stall_cnt  out  STALL_CNT_WIDTH  saturating count of hazard-stall cycles

## Operation
- Entry layout (LSB up): [0] taken, [32:1] nxt_pc, [64:33] cur_pc, [65] rd_wen, [70:66] rd, [75:71] rs2, [80:76] rs1, [112:81] imm, [116:113] operator, [118:117] operand type, [120:119] function type, [122:121] reserved, ignored.
- rf_raddr1/2 = head rs1/rs2, driven continuously.
- hazard = busy[rs1] | busy[rs2] | (rd_wen & busy[rd]); busy[0] hardwired 0.
- issue_q_ren = issue_q_rok & !hazard & (!ex_valid | ex_ready) & !bpu_flush.
- Pop: output register loads head fields plus rf_rdata1/2; ex_valid<=1; busy[rd]<=1 if rd_wen & rd!=0.
- ex_valid & ex_ready & no pop: ex_valid<=0. Outputs hold while ex_valid & !ex_ready.
- wb_valid: busy[wb_rd]<=0. Same-cycle set and clear on same index: set wins.
- bpu_flush: ex_valid<=0; if held micro-op not accepted this cycle and has rd_wen, its busy bit cleared. Already-accepted micro-ops still write back normally.
- stall_cnt increments each cycle with issue_q_rok & hazard & !bpu_flush; saturates at all-ones.
- States (ex_valid): EMPTY -> FULL on pop; FULL -> EMPTY on accept without pop or on flush; FULL -> FULL on accept with pop.

## Timing
- Reset: ex_valid=0, all ex_* data=0, busy=0, stall_cnt=0; issue_q_ren=0 combinationally while RSTN low.
- Pop-to-ex_valid latency: 1 cycle. Back-to-back pops every cycle when hazard-free and ex_ready high.
- Dependent pair without bypass: consumer pops the cycle after wb_valid of its producer.
- Reset mid-operation discards held micro-op and scoreboard immediately.

## Configuration
- ISSUE_WB_BYPASS_EN defined: wb_valid with wb_rd==rs1/rs2 (nonzero) masks that source's busy bit this cycle and substitutes wb_data for rf_rdata at pop; consumer pops in the writeback cycle.
- Undefined: no forwarding; consumer waits one cycle after writeback.

## Structure
- issue_pkg: entry field offsets/widths, function/operand/operator type constants, NUM_REGS=32.
- Sub-module issue_scoreboard: busy vector, set/clear ports, three combinational lookup ports.

## Test plan
- Independent stream: 4 entries, ex_ready=1 -> issue_q_ren high 4 consecutive cycles, ex_valid 4 cycles starting 1 cycle later, stall_cnt=0.
- RAW: entry A rd=5, entry B rs1=5; wb_valid rd=5 at cycle 10 -> B pops cycle 11 (bypass: cycle 10, ex_rs1_data=wb_data 0xDEADBEEF).
- Backpressure: ex_ready=0 for 3 cycles with held op -> outputs stable, issue_q_ren=0, then accept resumes pops.
- Flush: held op rd=7 not accepted, bpu_flush=1 -> ex_valid=0 next cycle, busy[7]=0, no pop that cycle.
- x0 and collision: rd=0 never marks busy; wb clear and new set on rd=3 same cycle -> busy[3]=1.
- Saturation: force 70000 hazard cycles -> stall_cnt=0xFFFF.
